// File: rtl/accum_ctrl.sv
// rtl/accum_ctrl.sv - sequences the shared ACCUM adder through the eight predictor products per sample
module accum_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] WB1,
  input  logic [DW-1:0] WB2,
  input  logic [DW-1:0] WB3,
  input  logic [DW-1:0] WB4,
  input  logic [DW-1:0] WB5,
  input  logic [DW-1:0] WB6,
  input  logic [DW-1:0] WA1,
  input  logic [DW-1:0] WA2,
  input  logic [DW-1:0] S,
  output logic          clear,
  output logic [DW-1:0] W,
  output logic [DW-2:0] SEZ,
  output logic [DW-2:0] SE,
  output logic          busy,
  output logic          done,
  input  logic          scan_in0,
  input  logic          scan_in1,
  input  logic          scan_in2,
  input  logic          scan_in3,
  input  logic          scan_in4,
  input  logic          scan_enable,
  input  logic          test_mode,
  output logic          scan_out0,
  output logic          scan_out1,
  output logic          scan_out2,
  output logic          scan_out3,
  output logic          scan_out4
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_ACC  = 2'd2,
    ST_CAP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [2:0]    r_k;
  logic [2:0]    w_next_k;
  logic [2:0]    w_k_inc;
  logic [DW-1:0] r_op [8];
  logic          r_clear;
  logic          w_next_clear;
  logic [DW-1:0] r_w;
  logic [DW-1:0] w_next_w;
  logic [DW-2:0] r_sez;
  logic [DW-2:0] r_se;
  logic          r_busy;
  logic          r_done;
  logic          w_latch;
  logic          w_cap_sez;
  logic          w_cap_se;
  logic [4:0]    r_scan;
  logic          w_unused_s0;

  assign w_k_inc     = r_k + 3'd1;
  assign w_unused_s0 = S[0];

  // W and clear are computed one state ahead so they leave a flop and never glitch.
  always_comb begin
    w_next_state = r_state;
    w_next_k     = r_k;
    w_next_clear = 1'b0;
    w_next_w     = '0;
    w_latch      = 1'b0;
    w_cap_sez    = 1'b0;
    w_cap_se     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_latch      = 1'b1;
          w_next_state = ST_CLR;
          w_next_clear = 1'b1;
        end
      end
      ST_CLR: begin
        w_next_state = ST_ACC;
        w_next_k     = 3'd0;
        w_next_w     = r_op[0];
      end
      ST_ACC: begin
        if (r_k == 3'd6) begin
          w_cap_sez = 1'b1;
        end
        if (r_k == 3'd7) begin
          w_next_state = ST_CAP;
          w_next_k     = 3'd0;
        end else begin
          w_next_k = w_k_inc;
          w_next_w = r_op[w_k_inc];
        end
      end
      ST_CAP: begin
        w_cap_se     = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_k     = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_k     <= 3'd0;
      r_clear <= 1'b0;
      r_w     <= '0;
      r_sez   <= '0;
      r_se    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_k     <= w_next_k;
      r_clear <= w_next_clear;
      r_w     <= w_next_w;
      r_busy  <= (w_next_state != ST_IDLE);
      r_done  <= w_cap_se;
      if (w_cap_sez) begin
        r_sez <= S[DW-1:1];
      end
      if (w_cap_se) begin
        r_se <= S[DW-1:1];
      end
    end
  end

  // Operands are snapshotted at the start edge so callers may change them mid-sample.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        r_op[i] <= '0;
      end
    end else if (w_latch) begin
      r_op[0] <= WB1;
      r_op[1] <= WB2;
      r_op[2] <= WB3;
      r_op[3] <= WB4;
      r_op[4] <= WB5;
      r_op[5] <= WB6;
      r_op[6] <= WA1;
      r_op[7] <= WA2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_scan <= '0;
    end else if (scan_enable) begin
      r_scan <= {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};
    end
  end

  assign clear     = r_clear;
  assign W         = r_w;
  assign SEZ       = r_sez;
  assign SE        = r_se;
  assign busy      = r_busy;
  assign done      = r_done;
  assign scan_out0 = r_scan[0] & test_mode;
  assign scan_out1 = r_scan[1] & test_mode;
  assign scan_out2 = r_scan[2] & test_mode;
  assign scan_out3 = r_scan[3] & test_mode;
  assign scan_out4 = r_scan[4] & test_mode;

endmodule

// File: tb/tb_accum_ctrl.sv
// tb/tb_accum_ctrl.sv - scoreboard bench for accum_ctrl driving a behavioural ACCUM
module tb_accum_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] WB1, WB2, WB3, WB4, WB5, WB6, WA1, WA2;
  logic [15:0] S = '0;
  logic        clear;
  logic [15:0] W;
  logic [14:0] SEZ, SE;
  logic        busy, done;
  logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode;
  logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [14:0] sez;
    logic [14:0] se;
    int          c0;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  accum_ctrl #(.DW(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .WB1(WB1), .WB2(WB2), .WB3(WB3), .WB4(WB4), .WB5(WB5), .WB6(WB6),
    .WA1(WA1), .WA2(WA2), .S(S),
    .clear(clear), .W(W), .SEZ(SEZ), .SE(SE), .busy(busy), .done(done),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4),
    .scan_enable(scan_enable), .test_mode(test_mode),
    .scan_out0(scan_out0), .scan_out1(scan_out1), .scan_out2(scan_out2),
    .scan_out3(scan_out3), .scan_out4(scan_out4)
  );

  always #5 clk = ~clk;

  // ACCUM adder contract
  always @(posedge clk) begin
    if (clear) S <= '0;
    else       S <= S + W;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        m_e = q.pop_front();
        chk("SEZ", {17'd0, SEZ}, {17'd0, m_e.sez});
        chk("SE", {17'd0, SE}, {17'd0, m_e.se});
        chk("done_latency", cyc, m_e.c0 + 10);
      end
    end
  end

  task automatic set_ops(input logic [15:0] b1, b2, b3, b4, b5, b6, a1, a2);
    WB1 = b1; WB2 = b2; WB3 = b3; WB4 = b4; WB5 = b5; WB6 = b6; WA1 = a1; WA2 = a2;
  endtask

  function automatic logic [29:0] model(input logic [15:0] b1, b2, b3, b4, b5, b6, a1, a2);
    logic [15:0] sz, sa;
    sz = b1 + b2 + b3 + b4 + b5 + b6;
    sa = sz + a1 + a2;
    return {sz[15:1], sa[15:1]};
  endfunction

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || busy) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic apply(input logic [15:0] b1, b2, b3, b4, b5, b6, a1, a2,
                       input logic [14:0] esez, input logic [14:0] ese, input bit chk_clear);
    exp_t e;
    wait_idle();
    set_ops(b1, b2, b3, b4, b5, b6, a1, a2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    set_ops(16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h4321, 16'h8765);
    e.sez = esez; e.se = ese; e.c0 = cyc;
    q.push_back(e);
    if (chk_clear) begin
      @(negedge clk);
      chk("clear_after_E0", {31'd0, clear}, 32'd1);
      chk("busy_after_E0", {31'd0, busy}, 32'd1);
      chk("W_in_clr", {16'd0, W}, 32'd0);
      @(negedge clk);
      chk("clear_after_E1", {31'd0, clear}, 32'd0);
      chk("W_k0", {16'd0, W}, {16'd0, b1});
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [15:0] r [8];
    logic [29:0] m;
    exp_t e;
    reset = 1'b0; start = 1'b0;
    scan_in0 = 0; scan_in1 = 0; scan_in2 = 0; scan_in3 = 0; scan_in4 = 0;
    scan_enable = 0; test_mode = 0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_clear", {31'd0, clear}, 32'd0);
    chk("rst_W", {16'd0, W}, 32'd0);
    chk("rst_SEZ", {17'd0, SEZ}, 32'd0);
    chk("rst_SE", {17'd0, SE}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    apply(16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0100, 16'h0002,
          15'h0030, 15'h00B1, 1'b1);
    apply(16'hFFFE, 0, 0, 0, 0, 0, 0, 0, 15'h7FFF, 15'h7FFF, 1'b0);
    apply(0, 0, 0, 0, 0, 0, 0, 16'h0003, 15'h0000, 15'h0001, 1'b0);
    apply(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
          15'h7FFD, 15'h7FFC, 1'b0);
    drain();

    // start held high with operands changing every cycle: only edges 0, 11, 22, 33 latch
    for (int i = 0; i < 44; i++) begin
      for (int j = 0; j < 8; j++) r[j] = 16'($urandom);
      set_ops(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]);
      start = 1'b1;
      @(posedge clk); #1;
      if (i % 11 == 0) begin
        m = model(r[0], r[1], r[2], r[3], r[4], r[5], r[6], r[7]);
        e.sez = m[29:15]; e.se = m[14:0]; e.c0 = cyc;
        q.push_back(e);
      end
    end
    start = 1'b0;
    drain();

    set_ops(16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0100, 16'h0002);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_clear", {31'd0, clear}, 32'd0);
    chk("abort_W", {16'd0, W}, 32'd0);
    chk("abort_SEZ", {17'd0, SEZ}, 32'd0);
    chk("abort_SE", {17'd0, SE}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (12) @(posedge clk);
    #1;

    apply(16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0100, 16'h0002,
          15'h0030, 15'h00B1, 1'b0);
    drain();
    repeat (5) @(posedge clk);
    #1;
    chk("hold_SEZ", {17'd0, SEZ}, 32'h30);
    chk("hold_SE", {17'd0, SE}, 32'hB1);
    chk("queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
